// File: rtl/sprite_controller_bullets_multi.sv
// sprite_controller_bullets_multi: per-pixel multi-bullet hit test and bullet-ROM address generator (optional BULLET_SCALE2X_EN draws each ROM pixel as 2x2)
module sprite_controller_bullets_multi #(
  parameter int N_BULLETS = 4,
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8,
  parameter int CORDW = 10,
  parameter int ADDRW = 8,
  parameter int LATCH_LINE = 0,
  localparam int IDW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CORDW-1:0]           pixel,
  input  logic [CORDW-1:0]           line,
  input  logic [N_BULLETS*CORDW-1:0] bullet_x,
  input  logic [N_BULLETS*CORDW-1:0] bullet_y,
  input  logic [N_BULLETS-1:0]       bullet_active,
  output logic [ADDRW-1:0]           addr,
  output logic                       rden,
  output logic [IDW-1:0]             bullet_id,
  output logic                       overlap
);
  localparam int XW = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
  localparam int YW = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;
`ifdef BULLET_SCALE2X_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  localparam logic [CORDW:0] W_EFF = (CORDW+1)'(BULLET_W << SH);
  localparam logic [CORDW:0] H_EFF = (CORDW+1)'(BULLET_H << SH);

  logic [N_BULLETS-1:0][CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [N_BULLETS-1:0]            sa_q, sa_d, hit_q, hit_d;
  logic [N_BULLETS-1:0][XW-1:0]    dx_q, dx_d;
  logic [N_BULLETS-1:0][YW-1:0]    dy_q, dy_d;
  logic [ADDRW-1:0]                addr_q, addr_d;
  logic                            rden_q, rden_d, ovl_q, ovl_d;
  logic [IDW-1:0]                  id_q, id_d;
  logic                            latch;

  assign latch = (line == CORDW'(LATCH_LINE)) && (pixel == '0);

  // Shadow coordinates: refreshed once per frame so mid-frame updates never tear
  always_comb begin
    sx_d = latch ? bullet_x : sx_q;
    sy_d = latch ? bullet_y : sy_q;
    sa_d = latch ? bullet_active : sa_q;
  end

  // Stage 1: per-slot box test at CORDW+1 bits (no wrap near the edge) plus in-sprite offsets
  always_comb begin
    hit_d = '0;
    dx_d  = '0;
    dy_d  = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      hit_d[i] = sa_q[i]
               && ({1'b0, pixel} >= {1'b0, sx_q[i]}) && ({1'b0, pixel} < {1'b0, sx_q[i]} + W_EFF)
               && ({1'b0, line} >= {1'b0, sy_q[i]}) && ({1'b0, line} < {1'b0, sy_q[i]} + H_EFF);
      dx_d[i] = XW'((pixel - sx_q[i]) >> SH);
      dy_d[i] = YW'((line - sy_q[i]) >> SH);
    end
  end

  // Stage 2: lowest-index hit wins; address is slot base plus row-major offset
  always_comb begin
    addr_d = '0;
    id_d   = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        id_d   = IDW'(i);
        addr_d = ADDRW'(i * BULLET_W * BULLET_H + int'(dy_q[i]) * BULLET_W + int'(dx_q[i]));
      end
    end
    rden_d = |hit_q;
    ovl_d  = $countones(hit_q) > 1;
  end

  // State registers; reset clears shadows and both stages and wins over the latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      sa_q   <= '0;
      hit_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      addr_q <= '0;
      rden_q <= 1'b0;
      id_q   <= '0;
      ovl_q  <= 1'b0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      sa_q   <= sa_d;
      hit_q  <= hit_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      addr_q <= addr_d;
      rden_q <= rden_d;
      id_q   <= id_d;
      ovl_q  <= ovl_d;
    end
  end

  assign addr      = addr_q;
  assign rden      = rden_q;
  assign bullet_id = id_q;
  assign overlap   = ovl_q;
endmodule

// File: tb/tb_sprite_controller_bullets_multi.sv
// tb_sprite_controller_bullets_multi: scoreboard bench with a box-test reference model of the bullet layer
module tb_sprite_controller_bullets_multi;
  localparam int N = 4, W = 4, H = 8, CW = 10, AW = 8, IW = 2;
`ifdef BULLET_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  typedef struct {
    int due;
    int a;
    bit r;
    int id;
    bit ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] pixel = '0, line = '0;
  logic [N*CW-1:0] bullet_x = '0, bullet_y = '0;
  logic [N-1:0]  bullet_active = '0;
  logic [AW-1:0] addr;
  logic          rden, overlap;
  logic [IW-1:0] bullet_id;

  exp_t q[$];
  exp_t got;
  int   cyc = 0, n_vec = 0, n_err = 0;
  int   mx[N], my[N], nx[N], ny[N];
  bit   ma[N], na[N];

  sprite_controller_bullets_multi dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .addr(addr), .rden(rden), .bullet_id(bullet_id), .overlap(overlap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each due expectation against the DUT outputs
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      got = q.pop_front();
      n_vec++;
      if (int'(addr) != got.a || rden !== got.r || int'(bullet_id) != got.id || overlap !== got.ov) begin
        n_err++;
        $display("FAIL out@cyc%0d: got addr=%0d rden=%b id=%0d ovl=%b, want addr=%0d rden=%b id=%0d ovl=%b",
                 cyc, addr, rden, bullet_id, overlap, got.a, got.r, got.id, got.ov);
      end
    end
  end

  task automatic set_b(input int i, input int x, input int y, input bit a);
    nx[i] = x; ny[i] = y; na[i] = a;
  endtask

  // Drive one pixel and push what the spec says should appear two cycles later
  task automatic step(input bit r, input int px, input int ln);
    exp_t e;
    int hits;
    @(negedge clk);
    rst_n = r;
    pixel = CW'(px);
    line  = CW'(ln);
    for (int i = 0; i < N; i++) begin
      bullet_x[i*CW +: CW] = CW'(nx[i]);
      bullet_y[i*CW +: CW] = CW'(ny[i]);
      bullet_active[i]     = na[i];
    end
    e = '{due: cyc + 2, a: 0, r: 1'b0, id: 0, ov: 1'b0};
    if (!r) begin
      if (q.size() > 0 && q[q.size()-1].due == cyc + 1)
        q[q.size()-1] = '{due: cyc + 1, a: 0, r: 1'b0, id: 0, ov: 1'b0};
      for (int i = 0; i < N; i++) begin
        mx[i] = 0; my[i] = 0; ma[i] = 1'b0;
      end
    end else begin
      hits = 0;
      for (int i = 0; i < N; i++) begin
        if (ma[i] && px >= mx[i] && px < mx[i] + W*S && ln >= my[i] && ln < my[i] + H*S) begin
          if (hits == 0) begin
            e.r  = 1'b1;
            e.id = i;
            e.a  = i*W*H + ((ln - my[i]) / S) * W + (px - mx[i]) / S;
          end
          hits++;
        end
      end
      e.ov = hits > 1;
      if (px == 0 && ln == 0)
        for (int i = 0; i < N; i++) begin
          mx[i] = nx[i]; my[i] = ny[i]; ma[i] = na[i];
        end
    end
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 1'b0; set_b(i, 0, 0, 1'b0);
    end
    set_b(1, 100, 50, 1'b1);
    repeat (3) step(1'b0, 102, 53);
    step(1'b1, 102, 53);
    step(1'b1, 5, 0);
    step(1'b1, 0, 0);
    step(1'b1, 102, 53);
    step(1'b1, 103, 53);
    step(1'b1, 104, 53);
    set_b(1, 0, 0, 1'b0);
    set_b(0, 10, 10, 1'b1);
    set_b(2, 10, 10, 1'b1);
    step(1'b1, 0, 0);
    step(1'b1, 10, 10);
    step(1'b1, 11, 12);
    set_b(2, 0, 0, 1'b0);
    set_b(0, 100, 100, 1'b1);
    step(1'b1, 0, 0);
    set_b(0, 200, 100, 1'b1);
    step(1'b1, 100, 100);
    step(1'b1, 200, 100);
    step(1'b1, 0, 0);
    step(1'b1, 100, 100);
    step(1'b1, 200, 100);
    set_b(0, 100, 50, 1'b1);
    step(1'b1, 0, 0);
    step(1'b1, 107, 65);
    step(1'b1, 108, 65);
    set_b(0, 1022, 0, 1'b1);
    step(1'b1, 0, 0);
    step(1'b1, 1022, 0);
    step(1'b1, 1023, 0);
    step(1'b1, 0, 0);
    step(1'b1, 1023, 7);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 63) == 0)
        for (int i = 0; i < N; i++)
          set_b(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 60)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 60)),
                   1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) step(1'b1, 0, 0);
      else if ($urandom_range(0, 199) == 0) repeat ($urandom_range(1, 3)) step(1'b0, 3, 3);
      else begin
        int j;
        j = int'($urandom_range(0, N-1));
        step(1'b1, (mx[j] + int'($urandom_range(0, W*S+3)) - 2) & 1023,
                   (my[j] + int'($urandom_range(0, H*S+3)) - 2) & 1023);
      end
    end
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_controller_bullets_multi.md
# sprite_controller_bullets_multi

Multi-bullet sprite address generator for the bullet layer of the video pipeline. It tracks `N_BULLETS` independent bullets and decides per pixel whether any active bullet covers the current raster position. For the covering bullet it computes a direct bullet-ROM address from the in-sprite offset, so no running counter is used. Bullet coordinates are latched once per frame so that game-logic updates never tear a frame.

## Interface
- `N_BULLETS`, 4: number of bullet slots; must be ≥1.
- `BULLET_W`, 4: sprite width in ROM pixels; power of two.
- `BULLET_H`, 8: sprite height in ROM pixels; power of two.
- `CORDW`, 10: raster coordinate width.
- `ADDRW`, 8: ROM address width; must be ≥ clog2(N_BULLETS·BULLET_W·BULLET_H).
- `LATCH_LINE`, 0: raster line on which coordinates are shadowed.
- `IDW`, derived as max(1, clog2(N_BULLETS)); not overridden.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `pixel` in CORDW: current raster column.
- `line` in CORDW: current raster row.
- `bullet_x` in N_BULLETS·CORDW: packed left edges; slot i occupies bits [i·CORDW +: CORDW].
- `bullet_y` in N_BULLETS·CORDW: packed top edges; same packing as `bullet_x`.
- `bullet_active` in N_BULLETS: per-slot enable.
- `addr` out ADDRW: registered ROM address.
- `rden` out 1: registered ROM read enable; high while a bullet covers the pixel.
- `bullet_id` out IDW: index of the selected slot.
- `overlap` out 1: high when more than one slot covers the pixel.

## Operation
- **Shadow latch.** In the cycle where `line==LATCH_LINE && pixel==0`, copy `bullet_x`, `bullet_y` and `bullet_active` into the shadow registers. All compares use only the shadow registers. A compare in the latch cycle uses the old shadow values.
- **Stage 1 (registered).** Per slot, compute hit = active & pixel≥x & pixel<x+W_eff & line≥y & line<y+H_eff.
  - Do the sums and compares at CORDW+1 bits so a box near 2^CORDW never wraps to column/row 0.
  - Register the hit vector and the per-slot offsets dx = pixel−x and dy = line−y, truncated to clog2(W)/clog2(H) bits.
- **Stage 2 (registered).**
  - Selected slot = lowest-index hit.
  - `addr` = id·W·H + dy·W + dx.
  - `rden` = OR of the hit vector.
  - `overlap` = popcount(hit) > 1.
- When nothing hits: `rden`=0, `addr`=0, `bullet_id`=0, `overlap`=0.
- `bullet_x` is the true left edge; there is no column offset. A slot with x or y beyond the visible area is simply never drawn.
- W_eff=BULLET_W and H_eff=BULLET_H unless scaling is enabled (see Configuration).

## Timing
- Latency is 2 clk cycles from `pixel`/`line` to `addr`/`rden`/`bullet_id`/`overlap`. The ROM's own read latency is absorbed downstream.
- Throughput is one pixel per cycle, with no stalls.
- New coordinates take effect at the first compare after the latch cycle. Between latches, changes on the inputs have no effect.
- Reset:
  - All outputs go to 0.
  - Both pipeline stages clear.
  - Shadow `active` clears to 0 and shadow coordinates clear to 0.
  - Reset asserted mid-frame blanks the bullets until the next latch after release.
- Reset has priority over the latch in the same cycle.

## Configuration
- `BULLET_SCALE2X_EN` defined:
  - W_eff=2·BULLET_W and H_eff=2·BULLET_H.
  - dx=(pixel−x)>>1 and dy=(line−y)>>1.
  - ROM layout and `addr` formula are unchanged.
  - Each ROM pixel is drawn as 2×2 screen pixels.
- `BULLET_SCALE2X_EN` undefined: 1:1 mapping with no shifts.

## Test plan
All scenarios use the defaults (N=4, W=4, H=8, so 32 words per slot).
- **Reset.** Hold rst_n=0 for 3 cycles with valid bullets on the inputs → `addr`=0, `rden`=0, `bullet_id`=0, `overlap`=0. After release, nothing is drawn until line 0/pixel 0 has passed.
- **Single hit.** Slot 1 at x=100, y=50, active and latched. Drive pixel=102, line=53 → 2 cycles later `rden`=1, `addr`=46, `bullet_id`=1. Drive pixel=104 → `rden`=0.
- **Overlap.** Slots 0 and 2 both at (10,10) and active. Drive pixel=10, line=10 → `bullet_id`=0, `addr`=0, `overlap`=1.
- **Tear-free update.** Move slot 0 from x=100 to x=200 at line 100 → the rest of the frame still hits at column 100. After the next latch, it hits only at column 200.
- **Right-edge boundary.** Slot 0 at x=1022, y=0. Sweep pixel=1022, 1023, 0 on line 0 → `addr`=0, 1, then `rden`=0 (no wrap).
- **BULLET_SCALE2X_EN build.** Slot 0 at (100,50). Drive pixel=107, line=65 → `addr`=31. Drive pixel=108 → `rden`=0.
